// File: rtl/axi_cache_bridge.sv
// axi_cache_bridge
// Turns cache-line refill (read) and writeback (write) requests into AXI4
// INCR bursts. One read and one write can be in flight at once. Each has its
// own state machine.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_rd_req_* / o_rd_req_ready   refill request (line address)
//   o_rd_rsp_*              refilled line, one-cycle valid pulse plus error flag
//   i_wr_req_* / o_wr_req_ready   writeback request (address, line, byte strobes)
//   o_wr_done, o_wr_err     writeback completion pulse and error flag
//   o_ar*/o_r*/o_aw*/o_w*/o_b* AXI master outputs, i_* AXI master inputs
module axi_cache_bridge #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         AXI_DATA_WIDTH = 128,
  parameter int         LINE_WIDTH     = 256,
  parameter logic [3:0] RD_ID          = 4'd0,
  parameter logic [3:0] WR_ID          = 4'd1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  // refill request / response
  input  logic                        i_rd_req_valid,
  output logic                        o_rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]       i_rd_req_addr,
  output logic                        o_rd_rsp_valid,
  output logic [LINE_WIDTH-1:0]       o_rd_rsp_data,
  output logic                        o_rd_rsp_err,
  // writeback request / completion
  input  logic                        i_wr_req_valid,
  output logic                        o_wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]       i_wr_req_addr,
  input  logic [LINE_WIDTH-1:0]       i_wr_req_data,
  input  logic [LINE_WIDTH/8-1:0]     i_wr_req_strb,
  output logic                        o_wr_done,
  output logic                        o_wr_err,
  // AXI read address / data
  output logic                        o_arvalid,
  output logic [ADDR_WIDTH-1:0]       o_araddr,
  output logic [7:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  output logic [3:0]                  o_arcache,
  output logic [3:0]                  o_arid,
  output logic [2:0]                  o_arprot,
  output logic [1:0]                  o_arlock,
  input  logic                        i_arready,
  input  logic                        i_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rlast,
  input  logic [3:0]                  i_rid,
  output logic                        o_rready,
  // AXI write address / data / response
  output logic                        o_awvalid,
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic [3:0]                  o_awcache,
  output logic [3:0]                  o_awid,
  output logic [2:0]                  o_awprot,
  output logic [1:0]                  o_awlock,
  input  logic                        i_awready,
  output logic                        o_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  input  logic                        i_wready,
  input  logic                        i_bvalid,
  input  logic [1:0]                  i_bresp,
  input  logic [3:0]                  i_bid,
  output logic                        o_bready
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int SW    = AXI_DATA_WIDTH / 8;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [7:0]    AXLEN     = 8'(BEATS - 1);
  localparam logic [2:0]    AXSIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_B    = 2'd3;

  logic [1:0]            r_rd_state;
  logic [BW-1:0]         r_rd_beat;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LINE_WIDTH-1:0] r_rd_line;
  logic                  r_rd_err;

  logic [1:0]              r_wr_state;
  logic [BW-1:0]           r_wr_beat;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [LINE_WIDTH-1:0]   r_wr_line;
  logic [LINE_WIDTH/8-1:0] r_wr_strb;

  logic w_rd_hazard;
  logic w_rd_accept;
  logic w_rd_beat_ok;
  logic w_rd_beat_last;
  logic w_wr_beat_last;
  logic w_unused;

  // Offset bits of request addresses and bid are intentionally not used.
  assign w_unused = ^{i_bid, i_rd_req_addr[OFF-1:0], i_wr_req_addr[OFF-1:0]};

  // A refill of a line whose writeback is still in flight must wait, otherwise
  // the read could overtake the write on the bus and return stale data.
  assign w_rd_hazard = (r_wr_state != W_IDLE) &&
                       (r_wr_addr[ADDR_WIDTH-1:OFF] == i_rd_req_addr[ADDR_WIDTH-1:OFF]);

  assign o_rd_req_ready = (r_rd_state == R_IDLE) && !w_rd_hazard;
  assign w_rd_accept    = i_rd_req_valid && o_rd_req_ready;

  // Beats tagged with a foreign ID belong to someone else and are dropped.
  assign w_rd_beat_ok   = i_rvalid && (i_rid == RD_ID);
  assign w_rd_beat_last = (r_rd_beat == LAST_BEAT);

  // Read FSM: request accept, AR handshake, beat collection, response pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_state <= R_IDLE;
      r_rd_beat  <= '0;
      r_rd_addr  <= '0;
      r_rd_line  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_rd_accept) begin
            r_rd_addr  <= {i_rd_req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            r_rd_beat  <= '0;
            r_rd_err   <= 1'b0;
            r_rd_state <= R_AR;
          end
        end
        R_AR: begin
          if (i_arready) begin
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rd_beat_ok) begin
            r_rd_line[int'(r_rd_beat)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
            if (w_rd_beat_last || i_rlast) begin
              // An rlast before the final beat means a short burst: flag it.
              r_rd_err   <= r_rd_err | (i_rresp != 2'b00) | !w_rd_beat_last;
              r_rd_state <= R_RESP;
            end else begin
              r_rd_err  <= r_rd_err | (i_rresp != 2'b00);
              r_rd_beat <= r_rd_beat + BW'(1);
            end
          end
        end
        R_RESP: begin
          r_rd_beat  <= '0;
          r_rd_state <= R_IDLE;
        end
        default: begin
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  assign w_wr_beat_last = (r_wr_beat == LAST_BEAT);

  // Write FSM: latch line, AW handshake, stream beats, wait for B.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_state <= W_IDLE;
      r_wr_beat  <= '0;
      r_wr_addr  <= '0;
      r_wr_line  <= '0;
      r_wr_strb  <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (i_wr_req_valid) begin
            r_wr_addr  <= {i_wr_req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            r_wr_line  <= i_wr_req_data;
            r_wr_strb  <= i_wr_req_strb;
            r_wr_beat  <= '0;
            r_wr_state <= W_AW;
          end
        end
        W_AW: begin
          if (i_awready) begin
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (i_wready) begin
            if (w_wr_beat_last) begin
              r_wr_state <= W_B;
            end else begin
              r_wr_beat <= r_wr_beat + BW'(1);
            end
          end
        end
        W_B: begin
          if (i_bvalid) begin
            r_wr_beat  <= '0;
            r_wr_state <= W_IDLE;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
        end
      endcase
    end
  end

  // Cache-side outputs
  assign o_rd_rsp_valid = (r_rd_state == R_RESP);
  assign o_rd_rsp_data  = r_rd_line;
  assign o_rd_rsp_err   = r_rd_err;
  assign o_wr_req_ready = (r_wr_state == W_IDLE);
  assign o_wr_done      = (r_wr_state == W_B) && i_bvalid;
  assign o_wr_err       = o_wr_done && (i_bresp != 2'b00);

  // AXI read channel: only registers and state decodes feed these
  assign o_arvalid = (r_rd_state == R_AR);
  assign o_araddr  = r_rd_addr;
  assign o_arlen   = AXLEN;
  assign o_arsize  = AXSIZE;
  assign o_arburst = 2'b01;
  assign o_arcache = 4'b0000;
  assign o_arid    = RD_ID;
  assign o_arprot  = 3'b000;
  assign o_arlock  = 2'b00;
  assign o_rready  = (r_rd_state == R_DATA);

  // AXI write channel: beat slice selected by the registered beat counter
  assign o_awvalid = (r_wr_state == W_AW);
  assign o_awaddr  = r_wr_addr;
  assign o_awlen   = AXLEN;
  assign o_awsize  = AXSIZE;
  assign o_awburst = 2'b01;
  assign o_awcache = 4'b0000;
  assign o_awid    = WR_ID;
  assign o_awprot  = 3'b000;
  assign o_awlock  = 2'b00;
  assign o_wvalid  = (r_wr_state == W_DATA);
  assign o_wdata   = r_wr_line[int'(r_wr_beat)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign o_wstrb   = r_wr_strb[int'(r_wr_beat)*SW +: SW];
  assign o_wlast   = (r_wr_state == W_DATA) && w_wr_beat_last;
  assign o_bready  = (r_wr_state == W_B);

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Scoreboard bench for axi_cache_bridge (defaults: 128-bit bus, 256-bit line, 2 beats).
// Directed tests push expected AR/AW/W/response records into queues; a monitor
// process pops and compares them whenever the DUT presents a handshake or pulse.
module tb_axi_cache_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_rd_req_valid, o_rd_req_ready;
  logic [31:0]  i_rd_req_addr;
  logic         o_rd_rsp_valid, o_rd_rsp_err;
  logic [255:0] o_rd_rsp_data;
  logic         i_wr_req_valid, o_wr_req_ready;
  logic [31:0]  i_wr_req_addr;
  logic [255:0] i_wr_req_data;
  logic [31:0]  i_wr_req_strb;
  logic         o_wr_done, o_wr_err;
  logic         o_arvalid, i_arready;
  logic [31:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic [3:0]   o_arcache, o_arid;
  logic [2:0]   o_arprot;
  logic [1:0]   o_arlock;
  logic         i_rvalid, i_rlast, o_rready;
  logic [127:0] i_rdata;
  logic [1:0]   i_rresp;
  logic [3:0]   i_rid;
  logic         o_awvalid, i_awready;
  logic [31:0]  o_awaddr;
  logic [7:0]   o_awlen;
  logic [2:0]   o_awsize;
  logic [1:0]   o_awburst;
  logic [3:0]   o_awcache, o_awid;
  logic [2:0]   o_awprot;
  logic [1:0]   o_awlock;
  logic         o_wvalid, o_wlast, i_wready;
  logic [127:0] o_wdata;
  logic [15:0]  o_wstrb;
  logic         i_bvalid, o_bready;
  logic [1:0]   i_bresp;
  logic [3:0]   i_bid;

  axi_cache_bridge dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req_valid(i_rd_req_valid), .o_rd_req_ready(o_rd_req_ready), .i_rd_req_addr(i_rd_req_addr),
    .o_rd_rsp_valid(o_rd_rsp_valid), .o_rd_rsp_data(o_rd_rsp_data), .o_rd_rsp_err(o_rd_rsp_err),
    .i_wr_req_valid(i_wr_req_valid), .o_wr_req_ready(o_wr_req_ready), .i_wr_req_addr(i_wr_req_addr),
    .i_wr_req_data(i_wr_req_data), .i_wr_req_strb(i_wr_req_strb), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arcache(o_arcache), .o_arid(o_arid), .o_arprot(o_arprot), .o_arlock(o_arlock),
    .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rid(i_rid), .o_rready(o_rready),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awcache(o_awcache), .o_awid(o_awid), .o_awprot(o_awprot), .o_awlock(o_awlock),
    .i_awready(i_awready), .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .i_wready(i_wready), .i_bvalid(i_bvalid), .i_bresp(i_bresp), .i_bid(i_bid), .o_bready(o_bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // free-running cycle counter used to compare accept cycles
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard queues
  logic [31:0]  ar_q[$];
  logic [31:0]  aw_q[$];
  logic [144:0] w_q[$];   // {data, strb, last}
  logic [256:0] rd_q[$];  // {err, line}
  logic         wr_q[$];

  // read slave configuration
  int           ar_delay = 0;
  int           ar_cnt   = 0;
  bit           r_go     = 1'b0;
  int           r_idx    = 0;
  int           r_n      = 0;
  int           gap_cnt  = 0;
  logic [127:0] r_data[4];
  logic [1:0]   r_resp[4];
  logic [3:0]   r_id[4];
  logic         r_last[4];
  int           r_gap[4];
  // write slave configuration
  bit           w_toggle   = 1'b0;
  int           b_delay    = 0;
  int           b_cnt      = 0;
  logic [1:0]   b_resp_cfg = 2'b00;

  localparam logic [127:0] DA = {4{32'hA0A0_0001}}, DB = {4{32'hB0B0_0002}};
  localparam logic [127:0] DC = {4{32'hC0C0_0003}}, DD = {4{32'hD0D0_0004}};
  localparam logic [127:0] DE = {4{32'hE0E0_0005}}, DF = {4{32'hF0F0_0006}};
  localparam logic [127:0] DG = {4{32'h6060_0007}}, DH = {4{32'h7070_0008}};
  localparam logic [127:0] DI = {4{32'h8080_0009}}, DJ = {4{32'h9090_000A}};
  localparam logic [127:0] DK = {4{32'h1212_000B}}, DL = {4{32'h1313_000C}};
  localparam logic [127:0] DM = {4{32'h1414_000D}}, DN0 = {4{32'h1515_000E}};
  localparam logic [127:0] DN1 = {4{32'h1616_000F}}, DX = {4{32'h9999_9999}};
  localparam logic [127:0] W0 = {4{32'h1111_0000}}, W1 = {4{32'h2222_0001}};
  localparam logic [127:0] X0 = {4{32'h3333_0000}}, X1 = {4{32'h4444_0001}};

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event occurred, none was required", name);
  endtask

  task automatic set_beat(input int i, input logic [127:0] d, input logic [1:0] rs,
                          input logic [3:0] id, input logic l, input int g);
    r_data[i] = d; r_resp[i] = rs; r_id[i] = id; r_last[i] = l; r_gap[i] = g;
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [255:0] line, input logic err);
    ar_q.push_back(a);
    rd_q.push_back({err, line});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [255:0] d, input logic [31:0] s, input logic err);
    aw_q.push_back(a);
    w_q.push_back({d[127:0], s[15:0], 1'b0});
    w_q.push_back({d[255:128], s[31:16], 1'b1});
    wr_q.push_back(err);
  endtask

  task automatic rd_issue(input logic [31:0] a, output int acc);
    int n = 0;
    @(posedge clk); #1;
    i_rd_req_valid = 1'b1; i_rd_req_addr = a;
    @(negedge clk);
    while (!o_rd_req_ready && n < 100) begin n++; @(negedge clk); end
    check("rd_accept", o_rd_req_ready, 1'b1);
    @(posedge clk);
    acc = cyc;
    #1 i_rd_req_valid = 1'b0;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [255:0] d, input logic [31:0] s, output int acc);
    int n = 0;
    @(posedge clk); #1;
    i_wr_req_valid = 1'b1; i_wr_req_addr = a; i_wr_req_data = d; i_wr_req_strb = s;
    @(negedge clk);
    while (!o_wr_req_ready && n < 100) begin n++; @(negedge clk); end
    check("wr_accept", o_wr_req_ready, 1'b1);
    @(posedge clk);
    acc = cyc;
    #1 i_wr_req_valid = 1'b0;
  endtask

  task automatic wait_rd_done();
    int n = 0;
    while (rd_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("rd_done_timeout", rd_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ar_q.size() + aw_q.size() + w_q.size() + rd_q.size() + wr_q.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain", ar_q.size() + aw_q.size() + w_q.size() + rd_q.size() + wr_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // monitor: compares every handshake / pulse against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_arvalid) begin
          if (ar_q.size() == 0) fail("ar_unexpected");
          else if (i_arready)
            check("ar_fields", {o_araddr, o_arlen, o_arsize, o_arburst, o_arcache, o_arid, o_arprot, o_arlock},
                  {ar_q.pop_front(), 8'd1, 3'd4, 2'b01, 4'd0, 4'd0, 3'd0, 2'b00});
          else check("araddr_stall", o_araddr, ar_q[0]);
        end
        if (o_awvalid) begin
          if (aw_q.size() == 0) fail("aw_unexpected");
          else if (i_awready)
            check("aw_fields", {o_awaddr, o_awlen, o_awsize, o_awburst, o_awcache, o_awid, o_awprot, o_awlock},
                  {aw_q.pop_front(), 8'd1, 3'd4, 2'b01, 4'd0, 4'd1, 3'd0, 2'b00});
        end
        if (o_wvalid) begin
          if (w_q.size() == 0) fail("w_unexpected");
          else if (i_wready) check("w_beat", {o_wdata, o_wstrb, o_wlast}, w_q.pop_front());
          else check("w_stall", {o_wdata, o_wstrb, o_wlast}, w_q[0]);
        end
        if (o_rd_rsp_valid) begin
          if (rd_q.size() == 0) fail("rd_rsp_unexpected");
          else check("rd_rsp", {o_rd_rsp_err, o_rd_rsp_data}, rd_q.pop_front());
        end
        if (o_wr_done) begin
          if (wr_q.size() == 0) fail("wr_done_unexpected");
          else check("wr_err", o_wr_err, wr_q.pop_front());
        end
      end
    end
  end

  // AXI read slave: AR stall then scripted R beats with gaps
  initial begin
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rlast = 1'b0; i_rid = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0;
        r_go = 1'b0; r_idx = 0; ar_cnt = 0; gap_cnt = 0;
      end else begin
        if (i_arready) begin
          i_arready = 1'b0; ar_cnt = 0; r_go = 1'b1; r_idx = 0; gap_cnt = 0;
        end else if (o_arvalid) begin
          if (ar_cnt >= ar_delay) i_arready = 1'b1;
          else ar_cnt++;
        end
        if (i_rvalid) r_idx++;
        i_rvalid = 1'b0; i_rlast = 1'b0;
        if (r_go && r_idx < r_n) begin
          if (gap_cnt < r_gap[r_idx]) gap_cnt++;
          else begin
            i_rvalid = 1'b1; i_rdata = r_data[r_idx]; i_rresp = r_resp[r_idx];
            i_rid = r_id[r_idx]; i_rlast = r_last[r_idx]; gap_cnt = 0;
          end
        end else begin
          r_go = 1'b0;
        end
      end
    end
  end

  // AXI write slave: immediate AW, optional toggling wready, delayed B
  initial begin
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00; i_bid = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; b_cnt = 0;
      end else begin
        if (i_awready) i_awready = 1'b0;
        else if (o_awvalid) i_awready = 1'b1;
        if (o_wvalid) i_wready = w_toggle ? ~i_wready : 1'b1;
        else i_wready = 1'b0;
        if (i_bvalid) begin
          i_bvalid = 1'b0; i_bresp = 2'b00; b_cnt = 0;
        end else if (o_bready) begin
          if (b_cnt >= b_delay) begin i_bvalid = 1'b1; i_bresp = b_resp_cfg; i_bid = 4'd1; end
          else b_cnt++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ca, cw, lat, n;
    rst = 1'b1;
    i_rd_req_valid = 1'b0; i_rd_req_addr = '0;
    i_wr_req_valid = 1'b0; i_wr_req_addr = '0; i_wr_req_data = '0; i_wr_req_strb = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {o_rd_req_ready, o_wr_req_ready, o_arvalid, o_rready, o_awvalid, o_wvalid,
                         o_bready, o_rd_rsp_valid, o_wr_done, o_rd_rsp_err}, 10'b11_0000_0000);
    check("reset_data", {o_rd_rsp_data, o_araddr, o_awaddr}, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_ctrl", {o_rd_req_ready, o_wr_req_ready, o_arvalid, o_awvalid, o_wvalid}, 5'b11000);

    // 1: minimum-latency read, unaligned address
    set_beat(0, DA, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DB, 2'b00, 4'd0, 1'b1, 0);
    r_n = 2;
    exp_read(32'h1000_0020, {DB, DA}, 1'b0);
    rd_issue(32'h1000_0024, ca);
    lat = 0;
    do begin lat++; @(negedge clk); end while (!o_rd_rsp_valid && lat < 50);
    check("rd_latency", lat, 4);
    wait_idle();

    // 2: AR stalled 5 cycles, gaps between R beats
    ar_delay = 5;
    set_beat(0, DC, 2'b00, 4'd0, 1'b0, 2);
    set_beat(1, DD, 2'b00, 4'd0, 1'b1, 3);
    r_n = 2;
    exp_read(32'h1000_0040, {DD, DC}, 1'b0);
    rd_issue(32'h1000_0040, ca);
    wait_idle();
    ar_delay = 0;

    // 3: writeback with toggling wready and SLVERR response
    w_toggle = 1'b1; b_resp_cfg = 2'b10; b_delay = 1;
    exp_write(32'h2000_0040, {W1, W0}, 32'hFFFF_FFFF, 1'b1);
    wr_issue(32'h2000_0040, {W1, W0}, 32'hFFFF_FFFF, cw);
    wait_idle();
    w_toggle = 1'b0; b_resp_cfg = 2'b00;

    // 4: concurrent accept of different lines, then same-line hazard
    b_delay = 8;
    set_beat(0, DN0, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DN1, 2'b00, 4'd0, 1'b1, 0);
    r_n = 2;
    exp_write(32'h3000_0000, {X1, X0}, 32'h0F0F_F0F0, 1'b0);
    exp_read(32'h4000_0000, {DN1, DN0}, 1'b0);
    fork
      rd_issue(32'h4000_0000, ca);
      wr_issue(32'h3000_0008, {X1, X0}, 32'h0F0F_F0F0, cw);
    join
    check("concurrent_accept", ca, cw);
    wait_rd_done();
    set_beat(0, DL, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DM, 2'b00, 4'd0, 1'b1, 0);
    r_n = 2;
    exp_read(32'h3000_0000, {DM, DL}, 1'b0);
    @(posedge clk); #1;
    i_rd_req_valid = 1'b1; i_rd_req_addr = 32'h3000_0010;
    @(negedge clk);
    n = 0;
    while (!o_wr_done && n < 50) begin
      check("hazard_block", o_rd_req_ready, 1'b0);
      n++;
      @(negedge clk);
    end
    check("hazard_wr_done_seen", o_wr_done, 1'b1);
    check("hazard_at_done", o_rd_req_ready, 1'b0);
    @(negedge clk);
    check("hazard_release", o_rd_req_ready, 1'b1);
    @(posedge clk); #1;
    i_rd_req_valid = 1'b0;
    wait_idle();
    b_delay = 0;

    // 6: reset during read beat 1, then a normal read
    set_beat(0, DH, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DI, 2'b00, 4'd0, 1'b1, 2);
    r_n = 2;
    exp_read(32'h7000_0000, {DI, DH}, 1'b0);
    rd_issue(32'h7000_0000, ca);
    n = 0;
    @(negedge clk);
    while (!(i_rvalid && o_rready && r_idx == 1) && n < 100) begin n++; @(negedge clk); end
    check("reached_beat1", {i_rvalid, o_rready}, 2'b11);
    #1 rst = 1'b1;
    rd_q.delete();
    #1;
    check("mid_reset_ctrl", {o_arvalid, o_rready, o_rd_rsp_valid, o_awvalid, o_wvalid, o_bready,
                             o_rd_req_ready, o_wr_req_ready}, 8'b0000_0011);
    check("mid_reset_data", o_rd_rsp_data, '0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    set_beat(0, DJ, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DK, 2'b00, 4'd0, 1'b1, 0);
    r_n = 2;
    exp_read(32'h7000_0080, {DK, DJ}, 1'b0);
    rd_issue(32'h7000_0084, ca);
    wait_idle();

    // 5: SLVERR on beat 1 with a foreign-ID beat (carrying rlast) in between
    set_beat(0, DE, 2'b00, 4'd0, 1'b0, 0);
    set_beat(1, DX, 2'b00, 4'd5, 1'b1, 1);
    set_beat(2, DF, 2'b10, 4'd0, 1'b1, 0);
    r_n = 3;
    exp_read(32'h5000_0000, {DF, DE}, 1'b1);
    rd_issue(32'h5000_0000, ca);
    wait_idle();

    // 7: early rlast on beat 0: upper half keeps previous line, error flagged
    set_beat(0, DG, 2'b00, 4'd0, 1'b1, 0);
    r_n = 1;
    exp_read(32'h6000_0020, {DF, DG}, 1'b1);
    rd_issue(32'h6000_0027, ca);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_cache_bridge.md
# axi_cache_bridge

Single-port AXI4 master front-end that converts cache-line refill and writeback requests from the cache side into AXI burst transactions on the core's external bus. Sits directly upstream of the AXI interface bundle and drives every master-side signal of it; the icache/dcache arbitration logic sits upstream of this block. One read and one write may be outstanding at once, each in its own FSM.

## Interface
- ADDR_WIDTH, 32: physical address width.
- AXI_DATA_WIDTH, 128: AXI data bus width; must divide LINE_WIDTH.
- LINE_WIDTH, 256: cache line width; BEATS = LINE_WIDTH/AXI_DATA_WIDTH, range 1..16.
- RD_ID, 4'd0 / WR_ID, 4'd1: fixed arid / awid values.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req_valid / rd_req_ready  in/out  1  refill request handshake.
- rd_req_addr  in  ADDR_WIDTH  refill address; low log2(LINE_WIDTH/8) bits ignored.
- rd_rsp_valid  out  1  one-cycle pulse: line returned.
- rd_rsp_data  out  LINE_WIDTH  refilled line, beat 0 in bits [AXI_DATA_WIDTH-1:0].
- rd_rsp_err  out  1  OR of all rresp!=0 for the burst, valid with rd_rsp_valid.
- wr_req_valid / wr_req_ready  in/out  1  writeback request handshake.
- wr_req_addr  in  ADDR_WIDTH; wr_req_data  in  LINE_WIDTH; wr_req_strb  in  LINE_WIDTH/8.
- wr_done  out  1  one-cycle pulse on B accepted; wr_err  out  1  bresp!=0, valid with wr_done.
- AXI master outputs: arvalid, araddr, arlen[7:0], arsize[2:0], arburst[1:0], arcache[3:0], arid[3:0], arprot[2:0], arlock[1:0], rready, awvalid, awaddr, awlen, awsize, awburst, awcache, awid[3:0], awprot, awlock, wvalid, wdata, wstrb, wlast, bready.
- AXI master inputs: arready, rvalid, rdata, rresp[1:0], rlast, rid[3:0], awready, wready, bvalid, bresp[1:0], bid[3:0].

## Operation
- Constants: ar/awlen = BEATS-1; ar/awsize = log2(AXI_DATA_WIDTH/8); ar/awburst = 2'b01 (INCR); cache 4'b0000, prot 3'b000, lock 2'b00.
- Addresses registered at request accept, line-aligned (low offset bits forced 0).
- Read FSM R_IDLE -> R_AR -> R_DATA -> R_RESP -> R_IDLE.
  - R_IDLE: rd_req_ready=1 unless hazard (below); accept -> R_AR.
  - R_AR: arvalid=1, fields stable until arready; -> R_DATA.
  - R_DATA: rready=1; each rvalid beat with rid==RD_ID stored at beat counter, counter++; beats with other rid ignored (rready still 1). Leave on beat with counter==BEATS-1 (rlast not required; rlast on earlier beat also ends burst, remaining line bits keep old contents, rd_rsp_err forced 1).
  - R_RESP: rd_rsp_valid=1 for exactly one cycle; -> R_IDLE.
- Write FSM W_IDLE -> W_AW -> W_DATA -> W_B -> W_IDLE.
  - W_IDLE: wr_req_ready=1; accept latches line, strb -> W_AW.
  - W_AW: awvalid=1 until awready. W_DATA: wvalid=1, wdata/wstrb = beat slice of line/strb, wlast=1 on beat BEATS-1; advance beat on wready.
  - W_B: bready=1; bvalid -> wr_done pulse same cycle as handshake, wr_err=(bresp!=0); -> W_IDLE.
- Hazard: rd_req_ready=0 while write FSM not W_IDLE and line addresses match (read-after-writeback ordering).
- Simultaneous rd and wr accepts in same cycle allowed (different lines).

## Timing
- Reset: all FSMs idle, beat counters 0, every valid/ready/pulse output 0 except rd_req_ready=wr_req_ready=1; data regs 0.
- Reset mid-burst: FSMs return to idle immediately; no completion pulse.
- Minimum read latency (arready and rvalid always high): accept cycle 0, arvalid cycle 1, beats cycles 2..BEATS+1, rd_rsp_valid cycle BEATS+2.
- Minimum write: awvalid cycle 1, W beats cycles 2..BEATS+1, wr_done in first cycle bvalid seen (>= BEATS+2).
- No combinational path from AXI inputs to AXI outputs except none; all AXI outputs are registered or decoded from FSM state.

## Test plan
- Read 0x1000_0024, BEATS=2, ready always high, rdata 0xA.., 0xB.. -> araddr=0x1000_0020, arlen=1, arsize=4, rd_rsp_data={B,A}, rd_rsp_valid at cycle 4, err=0.
- arready delayed 5 cycles, rvalid gaps -> araddr stable while stalled, correct line, single pulse.
- Write 0x2000_0040 with strb all-ones, wready toggling -> two W beats, wlast only on 2nd, bresp=2'b10 -> wr_done with wr_err=1.
- Write to 0x3000_0000 in flight, read 0x3000_0010 requested -> rd_req_ready=0 until wr_done cycle after; read 0x4000_0000 accepted concurrently.
- rresp=SLVERR on beat 1 only -> rd_rsp_err=1; foreign rid beat ignored.
- Assert rst during R_DATA beat 1 -> all valids 0 same cycle, no rd_rsp_valid, next request works normally.
